fetch_queue_unit: RTL and testbench

- Next-generation instruction fetcher. Fetches from the instruction cache, or from the memory controller on a miss, and predicts the next PC.
- Buffers fetched instructions in a parametrised queue, so fetch runs ahead of decode; decode pops through a valid/ready handshake.
- Sits between the icache/memory controller/branch predictor and the decoder. Flushed and redirected by the ROB.
- Drops stale memory responses after a flush. Optionally halts fetch on JALR.

---
 rtl/fetch_queue_unit_pkg.sv | 36 +++
 rtl/fetch_queue_unit_if.sv | 52 +++++
 rtl/fetch_queue_unit_inst_queue.sv | 75 +++++++
 rtl/fetch_queue_unit.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit_pkg
// Shared definitions for the fetch queue unit: basic word types, the opcode
// field width, the control-flow opcodes the fetcher predicts on, the fetch FSM
// state encoding and the immediate-extraction helpers.
// -----------------------------------------------------------------------------
package fetch_queue_unit_pkg;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] INST_TYPE;

  // Width of the opcode field at the bottom of every instruction word.
  localparam int OPTYPE_RANGE = 7;
  typedef logic [OPTYPE_RANGE-1:0] opcode_t;

  localparam opcode_t OP_JAL  = 7'b1101111;
  localparam opcode_t OP_BR   = 7'b1100011;
  localparam opcode_t OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  // J-type immediate as a signed byte offset (bit 0 is always zero).
  function automatic logic signed [20:0] j_imm(input INST_TYPE inst);
    return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // B-type immediate as a signed byte offset (bit 0 is always zero).
  function automatic logic signed [12:0] b_imm(input INST_TYPE inst);
    return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit_if
// Bundles every bus the fetcher talks on: icache lookup/refill, memory
// controller request/response, branch predictor query and the decode-side
// valid/ready queue head.
//   master : the fetch unit (drives if_to_*, dq_valid/PC/inst/pred_br/count)
//   slave  : the surrounding environment (drives ic_to_if_*, mc_to_if_*,
//            pr_to_if_prediction, dq_ready)
// -----------------------------------------------------------------------------
interface fetch_queue_unit_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CNT_WIDTH = $clog2(QUEUE_DEPTH) + 1;

  logic                  ic_to_if_hit;
  logic [INST_WIDTH-1:0] ic_to_if_hit_inst;
  logic [ADDR_WIDTH-1:0] if_to_ic_fetch_addr;
  logic [ADDR_WIDTH-1:0] if_to_ic_update_addr;
  logic [INST_WIDTH-1:0] if_to_ic_inst;
  logic                  if_to_ic_inst_valid;
  logic                  if_to_mc_ready;
  logic [ADDR_WIDTH-1:0] if_to_mc_PC;
  logic                  mc_to_if_ready;
  logic [INST_WIDTH-1:0] mc_to_if_inst;
  logic [ADDR_WIDTH-1:0] if_to_pr_PC;
  logic                  pr_to_if_prediction;
  logic                  dq_valid;
  logic                  dq_ready;
  logic [ADDR_WIDTH-1:0] dq_PC;
  logic [INST_WIDTH-1:0] dq_inst;
  logic                  dq_pred_br;
  logic [CNT_WIDTH-1:0]  dq_count;

  modport master (
    input  ic_to_if_hit, ic_to_if_hit_inst, mc_to_if_ready, mc_to_if_inst,
           pr_to_if_prediction, dq_ready,
    output if_to_ic_fetch_addr, if_to_ic_update_addr, if_to_ic_inst,
           if_to_ic_inst_valid, if_to_mc_ready, if_to_mc_PC, if_to_pr_PC,
           dq_valid, dq_PC, dq_inst, dq_pred_br, dq_count
  );

  modport slave (
    output ic_to_if_hit, ic_to_if_hit_inst, mc_to_if_ready, mc_to_if_inst,
           pr_to_if_prediction, dq_ready,
    input  if_to_ic_fetch_addr, if_to_ic_update_addr, if_to_ic_inst,
           if_to_ic_inst_valid, if_to_mc_ready, if_to_mc_PC, if_to_pr_PC,
           dq_valid, dq_PC, dq_inst, dq_pred_br, dq_count
  );

endinterface

// File: rtl/fetch_queue_unit_inst_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit_inst_queue
// Circular-buffer FIFO holding fetched {PC, instruction, prediction} entries.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   push, wdata      : append an entry (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   flush            : empty the queue, wins over push/pop
//   rdata            : head entry, read combinationally from the array
//   count/full/empty : occupancy status
// -----------------------------------------------------------------------------
module fetch_queue_unit_inst_queue #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [PW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (PW+1)'(DEPTH));
  assign empty     = (count_r == (PW+1)'(1'b0));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[head_r];
  assign count     = count_r;

  // Pointer and occupancy update; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok_s) tail_r <= tail_r + PW'(1'b1);
      if (pop_ok_s)  head_r <= head_r + PW'(1'b1);
      if (push_ok_s && !pop_ok_s) begin
        count_r <= count_r + (PW+1)'(1'b1);
      end else if (pop_ok_s && !push_ok_s) begin
        count_r <= count_r - (PW+1)'(1'b1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Entry storage, cleared on reset so the head never exposes unknown data.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s && !flush) begin
      mem_r[tail_r] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
// Instruction fetcher: looks up the icache at PC, falls back to the memory
// controller on a miss (refilling the icache afterwards), predicts the next PC
// from JAL/BR immediates and buffers fetched instructions for decode.
// Ports:
//   clk_in, rst_n_in   : clock, asynchronous active-low reset
//   rdy_in             : global ready, 0 freezes all state
//   clr_in             : ROB flush; PC is redirected to rob_to_if_alter_PC
//   bus (master)       : icache, memory controller, predictor and decode queue
// -----------------------------------------------------------------------------
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int INST_WIDTH    = 32,
  parameter int QUEUE_DEPTH   = 4,
  parameter int STALL_ON_JALR = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  clr_in,
  input  logic [ADDR_WIDTH-1:0] rob_to_if_alter_PC,
  fetch_queue_unit_if.master    bus
);
  localparam int CNT_WIDTH   = $clog2(QUEUE_DEPTH) + 1;
  localparam int ENTRY_WIDTH = ADDR_WIDTH + INST_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(32'd4);

  if_state_e             state_r,     state_nxt_s;
  logic [ADDR_WIDTH-1:0] pc_r,        pc_nxt_s;
  logic                  jalr_halt_r, jalr_halt_nxt_s;
  logic                  mc_req_r,    mc_req_nxt_s;
  logic [ADDR_WIDTH-1:0] mc_pc_r,     mc_pc_nxt_s;
  logic                  ic_valid_r,  ic_valid_nxt_s;
  logic [ADDR_WIDTH-1:0] ic_addr_r,   ic_addr_nxt_s;
  logic [INST_WIDTH-1:0] ic_inst_r,   ic_inst_nxt_s;

  logic                   push_s, pop_s, flush_s, fetch_en_s;
  logic [INST_WIDTH-1:0]  sel_inst_s;
  opcode_t                opcode_s;
  logic [ADDR_WIDTH-1:0]  jimm_ext_s, bimm_ext_s, next_pc_s;
  logic                   pred_s, is_jalr_s;
  logic [ENTRY_WIDTH-1:0] q_wdata_s, q_rdata_s;
  logic [CNT_WIDTH-1:0]   q_count_s;
  logic                   q_full_s, q_empty_s;

  // Full is exactly count == depth, so this matches "count below depth".
  assign fetch_en_s = ~q_full_s & ~jalr_halt_r;

  // The instruction being pushed comes from memory while a request is
  // outstanding and from the icache otherwise.
  assign sel_inst_s = (state_r == IF_WAIT) ? bus.mc_to_if_inst : bus.ic_to_if_hit_inst;
  assign opcode_s   = sel_inst_s[OPTYPE_RANGE-1:0];
  assign jimm_ext_s = ADDR_WIDTH'(j_imm(sel_inst_s));
  assign bimm_ext_s = ADDR_WIDTH'(b_imm(sel_inst_s));
  assign is_jalr_s  = (opcode_s == OP_JALR) && (STALL_ON_JALR != 0);
  assign q_wdata_s  = {pc_r, sel_inst_s, pred_s};

  // Next-PC prediction for the instruction currently being fetched.
  always_comb begin
    next_pc_s = pc_r + PC_STEP;
    pred_s    = 1'b0;
    case (opcode_s)
      OP_JAL: begin
        next_pc_s = pc_r + jimm_ext_s;
        pred_s    = 1'b1;
      end
      OP_BR: begin
        if (bus.pr_to_if_prediction) begin
          next_pc_s = pc_r + bimm_ext_s;
          pred_s    = 1'b1;
        end else begin
          next_pc_s = pc_r + PC_STEP;
          pred_s    = 1'b0;
        end
      end
      default: begin
        next_pc_s = pc_r + PC_STEP;
        pred_s    = 1'b0;
      end
    endcase
  end

  // Fetch FSM next state, queue controls and registered-output next values.
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    jalr_halt_nxt_s = jalr_halt_r;
    mc_req_nxt_s    = mc_req_r;
    mc_pc_nxt_s     = mc_pc_r;
    ic_valid_nxt_s  = 1'b0;
    ic_addr_nxt_s   = ic_addr_r;
    ic_inst_nxt_s   = ic_inst_r;
    push_s          = 1'b0;
    pop_s           = 1'b0;
    flush_s         = 1'b0;
    if (!rdy_in) begin
      // Registers are not loaded while frozen; only keep the pulse stable.
      ic_valid_nxt_s = ic_valid_r;
    end else if (clr_in) begin
      flush_s         = 1'b1;
      pc_nxt_s        = rob_to_if_alter_PC;
      jalr_halt_nxt_s = 1'b0;
      mc_req_nxt_s    = 1'b0;
      // A request still in flight (live or already stale) must have its
      // response swallowed, otherwise it would be taken for a newer fetch.
      state_nxt_s     = (state_r == IF_IDLE) ? IF_IDLE : IF_DISCARD;
    end else begin
      pop_s = ~q_empty_s & bus.dq_ready;
      case (state_r)
        IF_IDLE: begin
          if (fetch_en_s && bus.ic_to_if_hit) begin
            push_s          = 1'b1;
            pc_nxt_s        = next_pc_s;
            jalr_halt_nxt_s = jalr_halt_r | is_jalr_s;
          end else if (fetch_en_s) begin
            mc_req_nxt_s = 1'b1;
            mc_pc_nxt_s  = pc_r;
            state_nxt_s  = IF_WAIT;
          end else begin
            state_nxt_s = IF_IDLE;
          end
        end
        IF_WAIT: begin
          if (bus.mc_to_if_ready) begin
            // Space was reserved when the request was issued.
            push_s          = 1'b1;
            pc_nxt_s        = next_pc_s;
            jalr_halt_nxt_s = jalr_halt_r | is_jalr_s;
            mc_req_nxt_s    = 1'b0;
            ic_valid_nxt_s  = 1'b1;
            ic_addr_nxt_s   = pc_r;
            ic_inst_nxt_s   = bus.mc_to_if_inst;
            state_nxt_s     = IF_IDLE;
          end else begin
            state_nxt_s = IF_WAIT;
          end
        end
        IF_DISCARD: begin
          if (bus.mc_to_if_ready) begin
            state_nxt_s = IF_IDLE;
          end else begin
            state_nxt_s = IF_DISCARD;
          end
        end
        default: begin
          mc_req_nxt_s = 1'b0;
          state_nxt_s  = IF_IDLE;
        end
      endcase
    end
  end

  // State and registered-output update; rdy_in low holds everything.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r     <= IF_IDLE;
      pc_r        <= '0;
      jalr_halt_r <= 1'b0;
      mc_req_r    <= 1'b0;
      mc_pc_r     <= '0;
      ic_valid_r  <= 1'b0;
      ic_addr_r   <= '0;
      ic_inst_r   <= '0;
    end else if (rdy_in) begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      jalr_halt_r <= jalr_halt_nxt_s;
      mc_req_r    <= mc_req_nxt_s;
      mc_pc_r     <= mc_pc_nxt_s;
      ic_valid_r  <= ic_valid_nxt_s;
      ic_addr_r   <= ic_addr_nxt_s;
      ic_inst_r   <= ic_inst_nxt_s;
    end
  end

  fetch_queue_unit_inst_queue #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_inst_queue (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (flush_s),
    .wdata    (q_wdata_s),
    .rdata    (q_rdata_s),
    .count    (q_count_s),
    .full     (q_full_s),
    .empty    (q_empty_s)
  );

  assign bus.if_to_ic_fetch_addr  = pc_r;
  assign bus.if_to_pr_PC          = pc_r;
  assign bus.if_to_ic_update_addr = ic_addr_r;
  assign bus.if_to_ic_inst        = ic_inst_r;
  assign bus.if_to_ic_inst_valid  = ic_valid_r;
  assign bus.if_to_mc_ready       = mc_req_r;
  assign bus.if_to_mc_PC          = mc_pc_r;
  assign bus.dq_valid             = ~q_empty_s;
  assign bus.dq_count             = q_count_s;
  assign {bus.dq_PC, bus.dq_inst, bus.dq_pred_br} = q_rdata_s;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
// Self-checking bench: directed sequences, a table of prediction vectors and a
// randomized run against a transaction-level reference model. dut0 uses
// STALL_ON_JALR=0, dut1 uses STALL_ON_JALR=1; both see the same stimulus.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;
  localparam int QD = 4;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] JAL_P20 = 32'h0200006F;
  localparam logic [31:0] JAL_M4  = 32'hFFDFF06F;
  localparam logic [31:0] BR_M8   = 32'hFE000CE3;
  localparam logic [31:0] JALR_I  = 32'h00008067;
  localparam logic [31:0] ADDI    = 32'h00100093;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_n_in, rdy_in, clr_in;
  logic [31:0] alter_pc;
  logic        hit, pred, mc_rdy, dq_rdy;
  logic [31:0] hit_inst, mc_inst;
  int checks = 0;
  int errors = 0;

  fetch_queue_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32), .QUEUE_DEPTH(QD)) bus0 ();
  fetch_queue_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32), .QUEUE_DEPTH(QD)) bus1 ();

  assign bus0.ic_to_if_hit        = hit;
  assign bus0.ic_to_if_hit_inst   = hit_inst;
  assign bus0.mc_to_if_ready      = mc_rdy;
  assign bus0.mc_to_if_inst       = mc_inst;
  assign bus0.pr_to_if_prediction = pred;
  assign bus0.dq_ready            = dq_rdy;
  assign bus1.ic_to_if_hit        = hit;
  assign bus1.ic_to_if_hit_inst   = hit_inst;
  assign bus1.mc_to_if_ready      = mc_rdy;
  assign bus1.mc_to_if_inst       = mc_inst;
  assign bus1.pr_to_if_prediction = pred;
  assign bus1.dq_ready            = dq_rdy;

  fetch_queue_unit #(.ADDR_WIDTH(32), .INST_WIDTH(32), .QUEUE_DEPTH(QD), .STALL_ON_JALR(0)) dut0 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .rob_to_if_alter_PC(alter_pc), .bus(bus0));
  fetch_queue_unit #(.ADDR_WIDTH(32), .INST_WIDTH(32), .QUEUE_DEPTH(QD), .STALL_ON_JALR(1)) dut1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .rob_to_if_alter_PC(alter_pc), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; clr_in = 1'b0; alter_pc = 32'h0;
    hit = 1'b0; pred = 1'b0; mc_rdy = 1'b0; dq_rdy = 1'b0;
    hit_inst = NOP; mc_inst = NOP;
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_in = 1'b0;
    step(); step();
    rst_n_in = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    clr_in = 1'b1; alter_pc = target;
    step();
    clr_in = 1'b0;
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic pb; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_req_pc, m_ref_addr, m_ref_inst;
  bit          m_live, m_stale, m_refill;

  function automatic void predict(input logic [31:0] pc, input logic [31:0] inst,
                                  input logic p, output logic [31:0] npc, output logic pb);
    int imm;
    npc = pc + 32'd4;
    pb  = 1'b0;
    if (inst[6:0] == 7'h6F) begin
      imm = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096
          + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      npc = pc + 32'(imm);
      pb  = 1'b1;
    end else if (inst[6:0] == 7'h63 && p) begin
      imm = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048
          + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
      npc = pc + 32'(imm);
      pb  = 1'b1;
    end
  endfunction

  task automatic model_reset();
    mq.delete(); m_pc = 32'h0; m_req_pc = 32'h0; m_live = 0; m_stale = 0; m_refill = 0;
    m_ref_addr = 32'h0; m_ref_inst = 32'h0;
  endtask

  task automatic model_step();
    bit          do_pop, do_push;
    ent_t        e;
    logic [31:0] npc;
    logic        pb;
    int          sz;
    if (!rdy_in) return;
    if (clr_in) begin
      mq.delete();
      m_stale  = m_live || m_stale;
      m_live   = 0;
      m_pc     = alter_pc;
      m_refill = 0;
      return;
    end
    sz = mq.size();
    do_pop = (sz > 0) && dq_rdy;
    do_push = 0;
    m_refill = 0;
    if (m_stale) begin
      if (mc_rdy) m_stale = 0;
    end else if (m_live) begin
      if (mc_rdy) begin
        predict(m_pc, mc_inst, pred, npc, pb);
        e = '{m_pc, mc_inst, pb}; do_push = 1;
        m_refill = 1; m_ref_addr = m_pc; m_ref_inst = mc_inst;
        m_pc = npc; m_live = 0;
      end
    end else if (sz < QD) begin
      if (hit) begin
        predict(m_pc, hit_inst, pred, npc, pb);
        e = '{m_pc, hit_inst, pb}; do_push = 1;
        m_pc = npc;
      end else begin
        m_live = 1; m_req_pc = m_pc;
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(e);
  endtask

  task automatic model_compare();
    check("rnd_fetch_addr", bus0.if_to_ic_fetch_addr, m_pc);
    check("rnd_pr_pc", bus0.if_to_pr_PC, m_pc);
    check("rnd_count", 32'(bus0.dq_count), 32'(mq.size()));
    check("rnd_dq_valid", 32'(bus0.dq_valid), 32'(mq.size() > 0));
    check("rnd_mc_ready", 32'(bus0.if_to_mc_ready), 32'(m_live));
    if (m_live) check("rnd_mc_pc", bus0.if_to_mc_PC, m_req_pc);
    check("rnd_refill", 32'(bus0.if_to_ic_inst_valid), 32'(m_refill));
    if (m_refill) begin
      check("rnd_refill_addr", bus0.if_to_ic_update_addr, m_ref_addr);
      check("rnd_refill_inst", bus0.if_to_ic_inst, m_ref_inst);
    end
    if (mq.size() > 0) begin
      check("rnd_head_pc", bus0.dq_PC, mq[0].pc);
      check("rnd_head_inst", bus0.dq_inst, mq[0].inst);
      check("rnd_head_pred", 32'(bus0.dq_pred_br), 32'(mq[0].pb));
    end
  endtask

  // ---------------- prediction vector table ----------------
  typedef struct {
    logic [31:0] pc; logic [31:0] inst; logic pred_in;
    logic [31:0] exp_next; logic exp_pred;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h00000000, NOP,     1'b0, 32'h00000004, 1'b0};
    vecs[1] = '{32'h00000100, JAL_P20, 1'b0, 32'h00000120, 1'b1};
    vecs[2] = '{32'h00000200, BR_M8,   1'b1, 32'h000001F8, 1'b1};
    vecs[3] = '{32'h00000200, BR_M8,   1'b0, 32'h00000204, 1'b0};
    vecs[4] = '{32'h00000000, JAL_M4,  1'b0, 32'hFFFFFFFC, 1'b1};
    vecs[5] = '{32'h00000300, JALR_I,  1'b1, 32'h00000304, 1'b0};
    vecs[6] = '{32'hFFFFFFFC, NOP,     1'b0, 32'h00000000, 1'b0};

    idle_inputs();
    rst_n_in = 1'b0;
    do_reset();

    // Reset state
    check("rst_fetch_addr", bus0.if_to_ic_fetch_addr, 32'h0);
    check("rst_mc_ready", 32'(bus0.if_to_mc_ready), 32'd0);
    check("rst_mc_pc", bus0.if_to_mc_PC, 32'h0);
    check("rst_refill", 32'(bus0.if_to_ic_inst_valid), 32'd0);
    check("rst_update_addr", bus0.if_to_ic_update_addr, 32'h0);
    check("rst_ic_inst", bus0.if_to_ic_inst, 32'h0);
    check("rst_dq_valid", 32'(bus0.dq_valid), 32'd0);
    check("rst_count", 32'(bus0.dq_count), 32'd0);

    // Six hits into a four-entry queue with no pops
    hit = 1'b1; hit_inst = NOP;
    repeat (6) step();
    check("fill_count", 32'(bus0.dq_count), 32'd4);
    check("fill_pc", bus0.if_to_ic_fetch_addr, 32'h10);
    check("fill_no_mc", 32'(bus0.if_to_mc_ready), 32'd0);
    check("fill_head", bus0.dq_PC, 32'h0);

    // Pops from a full queue while hits continue; first pop frees no space
    dq_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pop_order", bus0.dq_PC, 32'(i * 4));
      step();
    end
    dq_rdy = 1'b0;
    check("overlap_count", 32'(bus0.dq_count), 32'd3);
    check("overlap_head", bus0.dq_PC, 32'h10);
    check("overlap_pc", bus0.if_to_ic_fetch_addr, 32'h1C);
    step();
    check("wrap_count", 32'(bus0.dq_count), 32'd4);
    check("wrap_pc", bus0.if_to_ic_fetch_addr, 32'h20);

    // Prediction table
    for (int v = 0; v < 7; v++) begin
      hit = 1'b0;
      redirect(vecs[v].pc);
      hit = 1'b1; hit_inst = vecs[v].inst; pred = vecs[v].pred_in;
      step();
      hit = 1'b0; pred = 1'b0;
      check("vec_count", 32'(bus0.dq_count), 32'd1);
      check("vec_pc", bus0.dq_PC, vecs[v].pc);
      check("vec_inst", bus0.dq_inst, vecs[v].inst);
      check("vec_pred", 32'(bus0.dq_pred_br), 32'(vecs[v].exp_pred));
      check("vec_next_pc", bus0.if_to_ic_fetch_addr, vecs[v].exp_next);
    end

    // Miss with a response three cycles later
    do_reset();
    redirect(32'h40);
    step();
    check("miss_mc_ready", 32'(bus0.if_to_mc_ready), 32'd1);
    check("miss_mc_pc", bus0.if_to_mc_PC, 32'h40);
    step(); step();
    check("miss_wait_empty", 32'(bus0.dq_valid), 32'd0);
    mc_rdy = 1'b1; mc_inst = ADDI;
    step();
    mc_rdy = 1'b0;
    check("resp_dq_valid", 32'(bus0.dq_valid), 32'd1);
    check("resp_dq_pc", bus0.dq_PC, 32'h40);
    check("resp_dq_inst", bus0.dq_inst, ADDI);
    check("resp_refill", 32'(bus0.if_to_ic_inst_valid), 32'd1);
    check("resp_update_addr", bus0.if_to_ic_update_addr, 32'h40);
    check("resp_ic_inst", bus0.if_to_ic_inst, ADDI);
    check("resp_mc_drop", 32'(bus0.if_to_mc_ready), 32'd0);
    check("resp_pc", bus0.if_to_ic_fetch_addr, 32'h44);
    step();
    check("refill_pulse_end", 32'(bus0.if_to_ic_inst_valid), 32'd0);
    check("next_miss_pc", bus0.if_to_mc_PC, 32'h44);

    // Flush while a request is outstanding; stale response dropped
    do_reset();
    redirect(32'h40);
    step();
    check("stale_req", 32'(bus0.if_to_mc_ready), 32'd1);
    redirect(32'h800);
    check("stale_flush_mc", 32'(bus0.if_to_mc_ready), 32'd0);
    check("stale_flush_pc", bus0.if_to_ic_fetch_addr, 32'h800);
    hit = 1'b1; hit_inst = NOP;
    step();
    hit = 1'b0;
    check("stale_no_fetch", 32'(bus0.dq_count), 32'd0);
    mc_rdy = 1'b1; mc_inst = ADDI;
    step();
    mc_rdy = 1'b0;
    check("stale_no_push", 32'(bus0.dq_count), 32'd0);
    check("stale_no_refill", 32'(bus0.if_to_ic_inst_valid), 32'd0);
    step();
    check("stale_new_req", 32'(bus0.if_to_mc_ready), 32'd1);
    check("stale_new_pc", bus0.if_to_mc_PC, 32'h800);

    // Global ready low freezes everything
    do_reset();
    hit = 1'b1; hit_inst = NOP;
    step();
    rdy_in = 1'b0;
    step(); step();
    check("frz_count", 32'(bus0.dq_count), 32'd1);
    check("frz_pc", bus0.if_to_ic_fetch_addr, 32'h4);
    rdy_in = 1'b1; hit = 1'b0;

    // JALR halt (dut1)
    do_reset();
    redirect(32'h300);
    hit = 1'b1; hit_inst = JALR_I;
    step();
    check("jalr_pushed", 32'(bus1.dq_count), 32'd1);
    check("jalr_head", bus1.dq_PC, 32'h300);
    hit_inst = NOP;
    step(); step();
    check("jalr_halt_count", 32'(bus1.dq_count), 32'd1);
    check("jalr_halt_pc", bus1.if_to_ic_fetch_addr, 32'h304);
    check("jalr_halt_no_mc", 32'(bus1.if_to_mc_ready), 32'd0);
    redirect(32'h500);
    check("jalr_clr_count", 32'(bus1.dq_count), 32'd0);
    step();
    check("jalr_resume_head", bus1.dq_PC, 32'h500);
    check("jalr_resume_pc", bus1.if_to_ic_fetch_addr, 32'h504);
    hit = 1'b0;

    // Randomized run against the reference model (dut0)
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      logic [6:0]  ops [4];
      ops[0] = 7'h6F; ops[1] = 7'h63; ops[2] = 7'h67; ops[3] = 7'h13;
      model_compare();
      rdy_in = ($urandom_range(0, 9) != 0);
      clr_in = ($urandom_range(0, 29) == 0);
      alter_pc = $urandom() & 32'hFFFF_FFFC;
      hit = ($urandom_range(0, 3) != 0);
      r = $urandom();
      hit_inst = {r[31:7], ops[$urandom_range(0, 3)]};
      r = $urandom();
      mc_inst = {r[31:7], ops[$urandom_range(0, 3)]};
      pred = 1'($urandom_range(0, 1));
      dq_rdy = 1'($urandom_range(0, 1));
      if (m_live || m_stale) mc_rdy = ($urandom_range(0, 2) == 0);
      else mc_rdy = ($urandom_range(0, 15) == 0);
      @(posedge clk_in);
      model_step();
      @(negedge clk_in);
    end
    model_compare();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
